// File: rtl/mmio_console_responder.sv
// mmio_console_responder
//   Data-bus responder (req/gnt/rvalid) for the core's data port. It provides a
//   console byte stream (PUTCHAR -> TX FIFO -> char_* stream) and a sticky exit
//   code (TOHOST), so programs can run on an FPGA without simulation monitors.
//
//   Register map, word index addr[3:2]:
//     0 PUTCHAR  W: push wdata[7:0] when be[0]   R: FIFO level
//     1 TOHOST   W: first full-word write latches the exit code   R: exit code
//     2 STATUS   R: {29'0, exit_valid, full, empty}
//     3 LOWAT    R/W low-water threshold (only with CONSOLE_LOWAT_IRQ_EN)
//
//   Ports:
//     clk_i, rst_i            clock, synchronous active-high reset
//     data_req_i .. wdata_i   core request (held until granted)
//     data_gnt_o              combinational grant
//     data_rvalid_o/rdata_o   registered response, one cycle after grant
//     char_valid/data/ready   TX FIFO head stream
//     exit_valid_o/code_o     sticky exit status
//     irq_o                   low-water / exit interrupt (0 unless the macro is set)
//
//   Optional feature macro: CONSOLE_LOWAT_IRQ_EN
module mmio_console_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o,
  output logic        irq_o
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned AW = LW - 1;

  typedef enum logic [1:0] {
    SEL_PUTCHAR = 2'd0,
    SEL_TOHOST  = 2'd1,
    SEL_STATUS  = 2'd2,
    SEL_LOWAT   = 2'd3
  } sel_e;

  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          exit_valid_q, exit_valid_d;
  logic [31:0]   exit_code_q, exit_code_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          hit, wr_acc, push, pop, empty, full, gnt;
  logic [LW-1:0] level, lowat_rd;
  logic [31:0]   rd_val;
  sel_e          sel;

  // Byte-offset bits carry no meaning for word registers.
  logic unused_addr;
  assign unused_addr = ^data_addr_i[1:0];

  assign sel   = sel_e'(data_addr_i[3:2]);
  assign hit   = (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (level == LW'(FIFO_DEPTH));

  // A PUTCHAR write against a full FIFO is stalled; the core retries. Full is
  // the registered state, so a pop in the same cycle does not open a slot.
  assign gnt    = data_req_i & ~rst_i &
                  ~(hit & data_we_i & (sel == SEL_PUTCHAR) & data_be_i[0] & full);
  assign wr_acc = gnt & hit & data_we_i;
  assign push   = wr_acc & (sel == SEL_PUTCHAR) & data_be_i[0];
  assign pop    = ~empty & char_ready_i;

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_PUTCHAR: rd_val[LW-1:0] = level;
      SEL_TOHOST:  rd_val = exit_code_q;
      SEL_STATUS:  rd_val = {29'd0, exit_valid_q, full, empty};
      SEL_LOWAT:   rd_val[LW-1:0] = lowat_rd;
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + LW'(push);
    rd_ptr_d     = rd_ptr_q + LW'(pop);
    rvalid_d     = gnt;
    rdata_d      = (gnt & hit & ~data_we_i) ? rd_val : '0;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    if (wr_acc && sel == SEL_TOHOST && data_be_i == 4'hF && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_code_d  = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_wdata_i[7:0];
  end

`ifdef CONSOLE_LOWAT_IRQ_EN
  logic [LW-1:0] lowat_q, lowat_d;
  logic          prev_nonempty_q, prev_nonempty_d;
  logic          irq_q, irq_d;

  // prev_nonempty arms the low-water interrupt once data has been queued;
  // software re-arms/acks by rewriting LOWAT.
  always_comb begin
    lowat_d         = lowat_q;
    prev_nonempty_d = prev_nonempty_q;
    irq_d           = exit_valid_q | (prev_nonempty_q & (level <= lowat_q));
    if (push) prev_nonempty_d = 1'b1;
    if (wr_acc && sel == SEL_LOWAT && data_be_i[0]) begin
      lowat_d         = data_wdata_i[LW-1:0];
      prev_nonempty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lowat_q         <= '0;
      prev_nonempty_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      lowat_q         <= lowat_d;
      prev_nonempty_q <= prev_nonempty_d;
      irq_q           <= irq_d;
    end
  end

  assign lowat_rd = lowat_q;
  assign irq_o    = irq_q;
`else
  assign lowat_rd = '0;
  assign irq_o    = 1'b0;
`endif

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign char_valid_o  = ~empty;
  assign char_data_o   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign exit_valid_o  = exit_valid_q;
  assign exit_code_o   = exit_code_q;
endmodule

// File: tb/tb_mmio_console_responder.sv
// Bench for mmio_console_responder: directed bus sequences, a queue-based
// reference model compared against every output each cycle, plus literal
// expectations at key points of each scenario.
module tb_mmio_console_responder;
  localparam int D = 16;
  localparam logic [31:0] A_PUT = 32'h0001_0000;
  localparam logic [31:0] A_TOH = 32'h0001_0004;
  localparam logic [31:0] A_STA = 32'h0001_0008;
  localparam logic [31:0] A_LOW = 32'h0001_000C;
  localparam logic [31:0] A_BAD = 32'h0002_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, ready = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        gnt, rvalid, cvalid, evalid, irq;
  logic [31:0] rdata, ecode;
  logic [7:0]  cdata;

  mmio_console_responder dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
    .data_wdata_i(wdata), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_rdata_o(rdata), .char_valid_o(cvalid), .char_data_o(cdata),
    .char_ready_i(ready), .exit_valid_o(evalid), .exit_code_o(ecode), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  logic [7:0]  mq[$];
  logic [7:0]  popped[$];
  logic        m_ev = 1'b0, m_rv = 1'b0, m_pn = 1'b0, m_irq = 1'b0;
  logic [31:0] m_ec = '0, m_rd = '0;
  int          m_low = 0;

  // Compare, then advance the model with this cycle's (stable) inputs.
  always @(negedge clk) begin
    logic e_gnt, h;
    logic [1:0] s;
    logic [31:0] rv;
    int sz;
    sz = mq.size();
    h  = (addr[31:4] == 28'h0001000);
    s  = addr[3:2];
    e_gnt = req && !rst && !(h && we && s == 2'd0 && be[0] && sz == D);
    check("gnt", gnt, e_gnt);
    check("rvalid", rvalid, m_rv);
    check("rdata", rdata, m_rd);
    check("char_valid", cvalid, sz != 0);
    check("char_data", cdata, sz != 0 ? mq[0] : 8'h00);
    check("exit_valid", evalid, m_ev);
    check("exit_code", ecode, m_ec);
    check("irq", irq, m_irq);
    if (!rst && cvalid && ready) popped.push_back(cdata);
    if (rst) begin
      mq.delete(); m_ev = 0; m_ec = 0; m_rv = 0; m_rd = 0;
      m_pn = 0; m_irq = 0; m_low = 0;
    end else begin
      case (s)
        2'd0: rv = 32'(sz);
        2'd1: rv = m_ec;
        2'd2: rv = {29'd0, m_ev, sz == D, sz == 0};
        default: rv = 32'(m_low);
      endcase
      m_rv = e_gnt;
      m_rd = (e_gnt && h && !we) ? rv : 32'd0;
`ifdef CONSOLE_LOWAT_IRQ_EN
      m_irq = m_ev | (m_pn && sz <= m_low);
`else
      m_irq = 1'b0;
`endif
      if (sz != 0 && ready) void'(mq.pop_front());
      if (e_gnt && h && we) begin
        if (s == 2'd0 && be[0]) begin mq.push_back(wdata[7:0]); m_pn = 1; end
        if (s == 2'd1 && be == 4'hF && !m_ev) begin m_ev = 1; m_ec = wdata; end
`ifdef CONSOLE_LOWAT_IRQ_EN
        if (s == 2'd3 && be[0]) begin m_low = int'(wdata[4:0]); m_pn = 0; end
`endif
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    int tries = 0;
    req = 1; addr = a; we = w; be = b; wdata = d;
    @(negedge clk);
    while (!gnt && tries < 50) begin
      @(posedge clk); #1; @(negedge clk); tries++;
    end
    check("bus_grant", gnt, 1'b1);
    @(posedge clk); #1;
    req = 0; we = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, input string name, input logic [31:0] exp);
    bus(a, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check({name, "_rvalid"}, rvalid, 1'b1);
    check(name, rdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 0; we = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    // act_sel: 0 evalid, 1 ecode, 2 rvalid, 3 cvalid, 4 irq
    @(negedge clk);
    case (act_sel)
      0: check(name, evalid, exp);
      1: check(name, ecode, exp);
      2: check(name, rvalid, exp);
      3: check(name, cvalid, exp);
      default: check(name, irq, exp);
    endcase
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_char_valid", cvalid, 1'b0);
    check("rst_char_data", cdata, 8'h00);
    check("rst_exit_valid", evalid, 1'b0);
    check("rst_irq", irq, 1'b0);
    @(posedge clk); #1;
    rst = 0;

    // 1: three chars with ready=1
    ready = 1;
    popped.delete();
    bus(A_PUT, 1, 4'h1, 32'h48);
    bus(A_PUT, 1, 4'h1, 32'h69);
    bus(A_PUT, 1, 4'h1, 32'h0A);
    idle(4);
    check("t1_count", popped.size(), 3);
    if (popped.size() == 3) begin
      check("t1_c0", popped[0], 8'h48);
      check("t1_c1", popped[1], 8'h69);
      check("t1_c2", popped[2], 8'h0A);
    end
    bus_read(A_PUT, "t1_level", 32'h0);

    // 2: fill with ready=0, overflow attempt stalls
    ready = 0;
    popped.delete();
    for (int i = 0; i < D; i++) bus(A_PUT, 1, 4'h1, 32'h40 + i);
    bus_read(A_STA, "t2_status_full", 32'h2);
    req = 1; addr = A_PUT; we = 1; be = 4'h1; wdata = 32'h50;
    repeat (3) begin
      @(negedge clk);
      check("t2_stall_gnt", gnt, 1'b0);
      @(posedge clk); #1;
    end
    ready = 1;
    bus(A_PUT, 1, 4'h1, 32'h50);
    idle(20);
    check("t2_count", popped.size(), D + 1);
    if (popped.size() == D + 1) begin
      for (int i = 0; i < D; i++) check("t2_byte", popped[i], 8'h40 + 8'(i));
      check("t2_last", popped[D], 8'h50);
    end
    bus_read(A_STA, "t2_status_empty", 32'h1);

    // 3: TOHOST
    bus(A_TOH, 1, 4'h3, 32'h7);
    peek("t3_partial_ignored", 0, 32'h0);
    bus(A_TOH, 1, 4'hF, 32'h0);
    peek("t3_exit_valid", 0, 32'h1);
    bus(A_TOH, 1, 4'hF, 32'h5);
    peek("t3_first_wins", 1, 32'h0);
    bus_read(A_TOH, "t3_read_code", 32'h0);

    // 4: back-to-back STATUS read, PUTCHAR read, unmapped write
    req = 1; we = 0; be = 4'hF; addr = A_STA;
    @(posedge clk); #1;
    addr = A_PUT;
    @(negedge clk);
    check("t4_rv0", rvalid, 1'b1); check("t4_status", rdata, 32'h5);
    @(posedge clk); #1;
    addr = A_BAD; we = 1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4_rv1", rvalid, 1'b1); check("t4_level", rdata, 32'h0);
    @(posedge clk); #1;
    req = 0; we = 0;
    @(negedge clk);
    check("t4_rv2", rvalid, 1'b1); check("t4_wr_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    peek("t4_rv_done", 2, 32'h0);
    bus_read(A_BAD, "t4_bad_read", 32'h0);
`ifdef CONSOLE_LOWAT_IRQ_EN
    bus(A_LOW, 1, 4'hF, 32'h3);
    bus_read(A_LOW, "t4_lowat", 32'h3);
`else
    bus(A_LOW, 1, 4'hF, 32'h5);
    bus_read(A_LOW, "t4_lowat_off", 32'h0);
    peek("t4_irq_off", 4, 32'h0);
`endif

    // 5: reset with a pending response and 3 queued bytes
    ready = 0;
    for (int i = 0; i < 3; i++) bus(A_PUT, 1, 4'h1, 32'h61 + i);
    req = 1; we = 0; addr = A_STA;
    @(posedge clk); #1;
    req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("t5_rvalid", rvalid, 1'b0);
    check("t5_char_valid", cvalid, 1'b0);
    check("t5_exit_valid", evalid, 1'b0);
    check("t5_exit_code", ecode, 32'h0);
    @(posedge clk); #1;

`ifdef CONSOLE_LOWAT_IRQ_EN
    // 6: low-water interrupt
    bus(A_LOW, 1, 4'hF, 32'h1);
    for (int i = 0; i < 3; i++) bus(A_PUT, 1, 4'h1, 32'h70 + i);
    ready = 1;
    begin
      int k = 0;
      @(negedge clk);
      while (!irq && k < 10) begin
        @(posedge clk); #1; @(negedge clk); k++;
      end
      check("t6_irq_rise", irq, 1'b1);
      @(posedge clk); #1;
    end
    bus(A_LOW, 1, 4'hF, 32'h1);
    idle(2);
    peek("t6_irq_cleared", 4, 32'h0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
